fix_to_float_stage: RTL and testbench
=====================================

Name: fix_to_float_stage

Overview:
- Output stage that follows the CORDIC rotator.
- Converts the rotator's signed two's-complement fixed-point cosine/sine word into an IEEE-754 single-precision float, ready for the custom-instruction result bus.
- Three-stage pipeline gated by clk_en, with a valid bit travelling alongside the data.
- Throughput is one conversion per enabled cycle.

Parameters:
- FRAC_W, 30: number of fractional bits in the fixed-point input (Q(32-FRAC_W).FRAC_W). Legal range 0..31.

Ports:
- clock  input  1  rising-edge clock
- aclr_n  input  1  asynchronous, active-low reset
- clk_en  input  1  pipeline advance enable; low freezes every stage
- in_valid  input  1  fix_in holds a word to convert
- fix_in  input  32  signed two's-complement fixed-point value
- out_valid  output  1  result holds a converted word
- result  output  32  IEEE-754 single (sign, 8-bit exponent, 23-bit fraction)

Behaviour:
- Reset:
  - aclr_n low asynchronously clears all pipeline registers.
  - out_valid=0, result=32'h0000_0000.
  - A conversion in flight when reset asserts is discarded; no partial output appears after release.
- Stall: when clk_en=0, no register updates and outputs hold their values, including out_valid.
- Latency:
  - in_valid/fix_in sampled on edge N with clk_en=1 appears on result/out_valid after 3 enabled edges.
  - Disabled cycles stretch the latency.
- Valid:
  - Every stage carries a valid bit.
  - Data registers load regardless of valid; only out_valid qualifies result.
  - Back-to-back inputs are accepted every enabled cycle.
- Stage 1 (sign/magnitude):
  - sign = fix_in[31].
  - mag = 32-bit unsigned |fix_in|; the negation is done unsigned, so 32'h8000_0000 gives mag=32'h8000_0000 (no overflow).
  - zero flag = (fix_in==0).
- Stage 2 (normalise):
  - lzc = leading-zero count of mag, 0..31 (don't-care when zero).
  - norm = mag << lzc, so norm[31]=1 for nonzero input.
  - Register sign, zero, lzc, norm.
- Stage 3 (round/pack):
  - exp = 127 + 31 - lzc - FRAC_W, 8-bit. With FRAC_W in range, exp stays within 1..254, so no denormal or infinity case exists.
  - frac = norm[30:8]; guard = norm[7]; sticky = |norm[6:0].
  - Rounding per the optional feature.
  - Rounding carry out of frac clears frac and increments exp.
  - Zero input packs to +0.0 = 32'h0000_0000, regardless of sign.
  - result = {sign, exp, frac}.
- No state machine beyond the pipeline; no back-pressure input. The downstream stage must consume out_valid in the cycle it is presented, or deassert clk_en.

Optional Feature:
- FIX2FLT_ROUND_EN defined:
  - Round to nearest, ties to even.
  - Increment frac when guard & (sticky | frac[0]).
- Not defined:
  - Truncate toward zero on magnitude: guard and sticky are ignored and no rounding adder is built.
  - Latency is unchanged (3).

Test Plan:
- Reset: hold aclr_n=0 → out_valid=0, result=0.
  - Release, then drive fix_in=32'h4000_0000 (1.0), in_valid=1, clk_en=1 → after 3 edges result=32'h3F80_0000, out_valid=1.
- Sign and zero:
  - 32'hC000_0000 → 32'hBF80_0000.
  - 32'h2000_0000 → 32'h3F00_0000.
  - 32'h0000_0000 → 32'h0000_0000.
  - 32'h8000_0000 (-2.0) → 32'hC000_0000.
  - 32'h0000_0001 → 32'h3080_0000 (2^-30).
- Rounding:
  - 32'h7FFF_FFFF with FIX2FLT_ROUND_EN → 32'h4000_0000 (carry into exponent).
  - Same input without the macro → 32'h3FFF_FFFF.
  - 32'h4000_0001 → 32'h3F80_0000 in both builds.
- Streaming: 10 consecutive valid words on consecutive enabled cycles → 10 consecutive out_valid cycles, in order, each matching a float reference model.
- Stall: drop clk_en for 4 cycles with 2 words in flight → outputs frozen throughout; words emerge in order once clk_en returns, total latency 3 enabled edges each.
- Mid-flight reset: assert aclr_n=0 one cycle after issuing a word → out_valid stays 0 after release until a new word completes.

Source files
------------

// File: rtl/fix_to_float_stage.sv
// Three-stage signed fixed-point to IEEE-754 single converter after the CORDIC rotator.
// Define FIX2FLT_ROUND_EN for round-to-nearest-even; the default build truncates.
module fix_to_float_stage #(
   parameter int FRAC_W = 30
) (
   input  logic        clock,
   input  logic        aclr_n,
   input  logic        clk_en,
   input  logic        in_valid,
   input  logic [31:0] fix_in,
   output logic        out_valid,
   output logic [31:0] result
);

   localparam logic [7:0] EXP_BASE = 8'(158 - FRAC_W);

   function automatic logic [4:0] lzc32(input logic [31:0] v);
      lzc32 = 5'd0;
      for (int i = 0; i < 32; i++) begin
         if (v[i]) lzc32 = 5'(31 - i);
      end
   endfunction

   logic        s1_v;
   logic        s1_sign;
   logic        s1_zero;
   logic [31:0] s1_mag;
   logic [31:0] mag_c;

   assign mag_c = fix_in[31] ? (~fix_in + 32'd1) : fix_in;

   always_ff @(posedge clock or negedge aclr_n) begin
      if (!aclr_n) begin
         s1_v    <= 1'b0;
         s1_sign <= 1'b0;
         s1_zero <= 1'b0;
         s1_mag  <= 32'd0;
      end else if (clk_en) begin
         s1_v    <= in_valid;
         s1_sign <= fix_in[31];
         s1_zero <= (fix_in == 32'd0);
         s1_mag  <= mag_c;
      end
   end

   logic        s2_v;
   logic        s2_sign;
   logic        s2_zero;
   logic [4:0]  s2_lzc;
   logic [4:0]  lzc_c;
   logic [22:0] s2_frac;
   logic [22:0] frac_c;

   assign lzc_c  = lzc32(s1_mag);
   assign frac_c = 23'((s1_mag << lzc_c) >> 8);

`ifdef FIX2FLT_ROUND_EN
   // Only the guard and the OR of the bits below it survive into stage 3.
   logic [7:0] low_c;
   logic       s2_grd;
   logic       s2_stk;

   assign low_c = 8'(s1_mag << lzc_c);
`endif

   always_ff @(posedge clock or negedge aclr_n) begin
      if (!aclr_n) begin
         s2_v    <= 1'b0;
         s2_sign <= 1'b0;
         s2_zero <= 1'b0;
         s2_lzc  <= 5'd0;
         s2_frac <= 23'd0;
`ifdef FIX2FLT_ROUND_EN
         s2_grd  <= 1'b0;
         s2_stk  <= 1'b0;
`endif
      end else if (clk_en) begin
         s2_v    <= s1_v;
         s2_sign <= s1_sign;
         s2_zero <= s1_zero;
         s2_lzc  <= lzc_c;
         s2_frac <= frac_c;
`ifdef FIX2FLT_ROUND_EN
         s2_grd  <= low_c[7];
         s2_stk  <= |low_c[6:0];
`endif
      end
   end

   logic [7:0]  exp_c;
   logic [7:0]  exp_r;
   logic [22:0] frac_r;
   logic [31:0] pack_c;

   assign exp_c = EXP_BASE - {3'd0, s2_lzc};

`ifdef FIX2FLT_ROUND_EN
   logic rnd_inc;
   logic carry;

   assign rnd_inc = s2_grd & (s2_stk | s2_frac[0]);
   // A carry out of the fraction leaves frac at zero and bumps the exponent.
   assign {carry, frac_r} = {1'b0, s2_frac} + {23'd0, rnd_inc};
   assign exp_r = exp_c + {7'd0, carry};
`else
   assign frac_r = s2_frac;
   assign exp_r  = exp_c;
`endif

   assign pack_c = s2_zero ? 32'd0 : {s2_sign, exp_r, frac_r};

   always_ff @(posedge clock or negedge aclr_n) begin
      if (!aclr_n) begin
         out_valid <= 1'b0;
         result    <= 32'd0;
      end else if (clk_en) begin
         out_valid <= s2_v;
         result    <= pack_c;
      end
   end

endmodule

// File: tb/tb_fix_to_float_stage.sv
// Directed bench for fix_to_float_stage with a double-precision reference model.
// Honours FIX2FLT_ROUND_EN to pick the rounding expectation.
module tb_fix_to_float_stage;

   logic        clock;
   logic        aclr_n;
   logic        clk_en;
   logic        in_valid;
   logic [31:0] fix_in;
   logic        out_valid;
   logic [31:0] result;

   int n_cmp;
   int n_bad;

   fix_to_float_stage #(.FRAC_W(30)) dut (
      .clock     (clock),
      .aclr_n    (aclr_n),
      .clk_en    (clk_en),
      .in_valid  (in_valid),
      .fix_in    (fix_in),
      .out_valid (out_valid),
      .result    (result)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Exact value in double, then narrowed to single.
   function automatic logic [31:0] model(input logic [31:0] x);
      real         r;
      logic [63:0] d;
      logic [31:0] f;
      int          e;
      if (x == 32'd0) return 32'd0;
      r = $itor($signed(x)) / 1073741824.0;
      d = $realtobits(r);
      e = int'(d[62:52]) - 1023 + 127;
      f = {d[63], 8'(e), d[51:29]};
`ifdef FIX2FLT_ROUND_EN
      if (d[28] && ((|d[27:0]) || d[29])) f = f + 32'd1;
`endif
      return f;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic send(input string tag, input logic [31:0] x,
                       input logic [31:0] expv);
      in_valid = 1'b1;
      fix_in   = x;
      @(negedge clock);
      in_valid = 1'b0;
      fix_in   = 32'd0;
      @(negedge clock);
      @(negedge clock);
      check({tag, "_v"}, {31'd0, out_valid}, 32'd1);
      check(tag, result, expv);
   endtask

   logic [31:0] vec [10];

   initial begin
      n_cmp    = 0;
      n_bad    = 0;
      aclr_n   = 1'b0;
      clk_en   = 1'b1;
      in_valid = 1'b1;
      fix_in   = 32'h1234_5678;
      vec[0] = 32'h1234_5678; vec[1] = 32'hFEDC_BA98;
      vec[2] = 32'h0000_0003; vec[3] = 32'h7FFF_FFC0;
      vec[4] = 32'h8000_0001; vec[5] = 32'h00FF_00FF;
      vec[6] = 32'hFFFF_FFFF; vec[7] = 32'h3FFF_FFFF;
      vec[8] = 32'h5555_5555; vec[9] = 32'hC000_0001;

      repeat (4) @(negedge clock);
      check("rst_valid", {31'd0, out_valid}, 32'd0);
      check("rst_result", result, 32'd0);
      in_valid = 1'b0;
      fix_in   = 32'd0;
      aclr_n   = 1'b1;
      @(negedge clock);

      send("one",      32'h4000_0000, 32'h3F80_0000);
      send("neg_one",  32'hC000_0000, 32'hBF80_0000);
      send("half",     32'h2000_0000, 32'h3F00_0000);
      send("zero",     32'h0000_0000, 32'h0000_0000);
      send("neg_two",  32'h8000_0000, 32'hC000_0000);
      send("lsb",      32'h0000_0001, 32'h3080_0000);
`ifdef FIX2FLT_ROUND_EN
      send("max_pos",  32'h7FFF_FFFF, 32'h4000_0000);
`else
      send("max_pos",  32'h7FFF_FFFF, 32'h3FFF_FFFF);
`endif
      send("one_lsb",  32'h4000_0001, 32'h3F80_0000);

      // Streaming: word c-3 is visible at negedge c.
      for (int c = 0; c < 14; c++) begin
         if (c >= 3 && c < 13) begin
            check($sformatf("strm_v%0d", c - 3), {31'd0, out_valid}, 32'd1);
            check($sformatf("strm%0d", c - 3), result, model(vec[c - 3]));
         end
         if (c == 13) check("strm_end_v", {31'd0, out_valid}, 32'd0);
         in_valid = (c < 10);
         fix_in   = (c < 10) ? vec[c] : 32'd0;
         @(negedge clock);
      end

      // Stall with w0 at the output and w1 one stage behind.
      in_valid = 1'b1;
      fix_in   = 32'hE000_0000;
      @(negedge clock);
      fix_in   = 32'h0C00_0000;
      @(negedge clock);
      in_valid = 1'b0;
      fix_in   = 32'd0;
      @(negedge clock);
      check("stall_pre_v", {31'd0, out_valid}, 32'd1);
      check("stall_pre", result, 32'hBF00_0000);
      clk_en   = 1'b0;
      in_valid = 1'b1;
      fix_in   = 32'h7777_7777;
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         check($sformatf("stall_v%0d", i), {31'd0, out_valid}, 32'd1);
         check($sformatf("stall%0d", i), result, 32'hBF00_0000);
      end
      in_valid = 1'b0;
      fix_in   = 32'd0;
      clk_en   = 1'b1;
      @(negedge clock);
      check("stall_w1_v", {31'd0, out_valid}, 32'd1);
      check("stall_w1", result, 32'h3E40_0000);
      @(negedge clock);
      check("stall_end_v", {31'd0, out_valid}, 32'd0);

      // Reset one cycle after issue discards the word.
      in_valid = 1'b1;
      fix_in   = 32'h4000_0000;
      @(negedge clock);
      in_valid = 1'b0;
      fix_in   = 32'd0;
      #2 aclr_n = 1'b0;
      #1;
      check("mid_rst_v", {31'd0, out_valid}, 32'd0);
      check("mid_rst", result, 32'd0);
      @(negedge clock);
      aclr_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         check($sformatf("post_rst_v%0d", i), {31'd0, out_valid}, 32'd0);
      end
      send("post_rst", 32'hF000_0000, 32'hBE80_0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
